// File: rtl/eth_rx_frame_check.sv
// -----------------------------------------------------------------------------
// eth_rx_frame_check
//
// Receive-side front end between the PHY byte interface and the frame parser.
// Removes the preamble/SFD, forwards frame bytes with the 4-byte FCS stripped,
// checks CRC-32 and frame length, and issues one good/bad verdict per frame.
// Keeps saturating good/bad frame counters for the status register block.
//
// Ports
//   clk          in   1   rx byte clock
//   rst          in   1   asynchronous, active-high reset
//   i_data       in   8   rx byte from PHY
//   i_data_vl    in   1   PHY data valid, high from preamble through FCS
//   o_data       out  8   frame byte (dst MAC .. last payload byte)
//   o_data_vl    out  1   o_data valid
//   o_sof        out  1   high with the first o_data_vl byte of a frame
//   o_eof        out  1   one-cycle pulse: frame ended, verdict valid
//   o_frame_ok   out  1   one-cycle pulse with o_eof, frame good
//   o_frame_err  out  1   one-cycle pulse with o_eof, frame bad
//   o_err_code   out  2   0 none, 1 CRC, 2 runt, 3 giant; held until next o_eof
//   o_good_cnt   out  16  good frames, saturating
//   o_bad_cnt    out  16  bad frames, saturating
// -----------------------------------------------------------------------------
module eth_rx_frame_check #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_data,
   input  logic        i_data_vl,
   output logic [7:0]  o_data,
   output logic        o_data_vl,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_frame_ok,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic [15:0] o_good_cnt,
   output logic [15:0] o_bad_cnt
);

   localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);
   localparam logic [10:0] LEN_MAX     = 11'(MAX_LEN);
   localparam logic [10:0] LEN_SAT     = 11'h7FF;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   // Register contents after a correct frame and its FCS have been shifted in
   // (no final inversion applied).
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_PREAMBLE,
      S_DATA,
      S_END,
      S_DROP
   } state_t;

   state_t      r_state;
   logic [31:0] r_crc;
   logic [10:0] r_len;
   logic [2:0]  r_dly_cnt;
   logic        r_first;
   logic [7:0]  r_dly [0:3];

   logic [7:0]  r_data;
   logic        r_data_vl;
   logic        r_sof;
   logic        r_eof;
   logic        r_ok;
   logic        r_err;
   logic [1:0]  r_err_code;
   logic [15:0] r_good_cnt;
   logic [15:0] r_bad_cnt;

   logic        w_push;
   logic [31:0] w_crc_next;
   logic [1:0]  w_err_code;

   // Reflected CRC-32 (poly 0x04C11DB7 as 0xEDB88320), one byte, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++) begin
         x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
      end
      return x;
   endfunction

   assign w_push     = (r_state == S_DATA) && i_data_vl;
   assign w_crc_next = crc32_byte(r_crc, i_data);

   // Verdict priority: giant over runt over CRC.
   always_comb begin
      w_err_code = 2'd0;
      if (r_len > LEN_MAX) begin
         w_err_code = 2'd3;
      end else if (r_len < LEN_MIN) begin
         w_err_code = 2'd2;
      end else if (r_crc != CRC_RESIDUE) begin
         w_err_code = 2'd1;
      end
   end

   // Four-byte delay line: holding back the newest four bytes means the FCS
   // is never forwarded. Pure datapath, so it carries no reset; r_dly_cnt
   // tracks how many entries are meaningful.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_dly[0] <= i_data;
         for (int k = 1; k < 4; k++) begin
            r_dly[k] <= r_dly[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_WAIT_IDLE;
         r_crc      <= '0;
         r_len      <= '0;
         r_dly_cnt  <= '0;
         r_first    <= 1'b0;
         r_data     <= '0;
         r_data_vl  <= 1'b0;
         r_sof      <= 1'b0;
         r_eof      <= 1'b0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= '0;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
      end else begin
         r_data_vl <= 1'b0;
         r_sof     <= 1'b0;
         r_eof     <= 1'b0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;

         case (r_state)
            // Skip whatever was on the wire when reset was released.
            S_WAIT_IDLE: begin
               if (!i_data_vl) begin
                  r_state <= S_IDLE;
               end
            end

            S_IDLE: begin
               if (i_data_vl) begin
                  r_state <= (i_data == 8'h55) ? S_PREAMBLE : S_DROP;
               end
            end

            S_PREAMBLE: begin
               if (!i_data_vl) begin
                  r_state <= S_IDLE;
               end else if (i_data == 8'hD5) begin
                  r_state   <= S_DATA;
                  r_crc     <= CRC_INIT;
                  r_len     <= '0;
                  r_dly_cnt <= '0;
                  r_first   <= 1'b1;
               end else if (i_data != 8'h55) begin
                  r_state <= S_DROP;
               end
            end

            S_DATA: begin
               if (i_data_vl) begin
                  r_crc <= w_crc_next;
                  if (r_len != LEN_SAT) begin
                     r_len <= r_len + 11'd1;
                  end
                  // Line already full: this push evicts the oldest byte.
                  if (r_dly_cnt == 3'd4) begin
                     r_data    <= r_dly[3];
                     r_data_vl <= 1'b1;
                     r_sof     <= r_first;
                     r_first   <= 1'b0;
                  end else begin
                     r_dly_cnt <= r_dly_cnt + 3'd1;
                  end
               end else begin
                  // Verdict is registered on the way into END so the pulses
                  // are visible during the END cycle itself.
                  r_state    <= S_END;
                  r_eof      <= 1'b1;
                  r_err_code <= w_err_code;
                  if (w_err_code == 2'd0) begin
                     r_ok <= 1'b1;
                     if (r_good_cnt != 16'hFFFF) begin
                        r_good_cnt <= r_good_cnt + 16'd1;
                     end
                  end else begin
                     r_err <= 1'b1;
                     if (r_bad_cnt != 16'hFFFF) begin
                        r_bad_cnt <= r_bad_cnt + 16'd1;
                     end
                  end
               end
            end

            // The byte present during END is not examined; IDLE samples the next one.
            S_END: begin
               r_state <= S_IDLE;
            end

            S_DROP: begin
               if (!i_data_vl) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_WAIT_IDLE;
            end
         endcase
      end
   end

   assign o_data      = r_data;
   assign o_data_vl   = r_data_vl;
   assign o_sof       = r_sof;
   assign o_eof       = r_eof;
   assign o_frame_ok  = r_ok;
   assign o_frame_err = r_err;
   assign o_err_code  = r_err_code;
   assign o_good_cnt  = r_good_cnt;
   assign o_bad_cnt   = r_bad_cnt;

endmodule
